// File: rtl/bcd_tick_counter.sv
// Prescaled single-digit up/down counter with registered active-low 7-segment outputs.
// Define HEX_MODE_EN for modulus-16 (0..F) counting; the default is decimal (0..9).
module bcd_tick_counter #(
  parameter int unsigned CLK_DIV = 100_000_000,
  parameter int unsigned DIV_W   = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       SEG_ZERO   = 7'b0000001;

`ifdef HEX_MODE_EN
  localparam logic [3:0] MAX = 4'hF;
`else
  localparam logic [3:0] MAX = 4'd9;
`endif

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       digit_q, digit_d;
  logic             wrap_q, wrap_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       load_fix;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
`ifdef HEX_MODE_EN
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      4'hF:    s = 7'b0111000;
`endif
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
`ifdef HEX_MODE_EN
    load_fix = load_val;
`else
    load_fix = (load_val > 4'd9) ? 4'd0 : load_val;
`endif
  end

  assign tick = en & (presc_q == PRESC_LAST);

  // Load wins over both the prescaler and the tick; wrap only follows a real tick.
  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      digit_d = load_fix;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (up) begin
          if (digit_q == MAX) begin
            digit_d = '0;
            wrap_d  = 1'b1;
          end else begin
            digit_d = digit_q + 4'd1;
          end
        end else begin
          if (digit_q == 4'd0) begin
            digit_d = MAX;
            wrap_d  = 1'b1;
          end else begin
            digit_d = digit_q - 4'd1;
          end
        end
      end
    end
  end

  assign seg_d = seg_decode(digit_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      digit_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_ZERO;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign digit = digit_q;
  assign wrap  = wrap_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with CLK_DIV=4; follows HEX_MODE_EN like the design.
module tb_bcd_tick_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;
  logic       a, b, c, d, e, f, g;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef HEX_MODE_EN
  localparam int MAX     = 15;
  localparam int LOAD12  = 12;
`else
  localparam int MAX     = 9;
  localparam int LOAD12  = 0;
`endif

  logic [6:0] SEG [16];

  bcd_tick_counter #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .digit(digit), .tick(tick), .wrap(wrap),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  assign seg = {a, b, c, d, e, f, g};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({digit, seg, tick, wrap} !== {4'd0, 7'b0000001, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_in got digit=%0d seg=%b tick=%b wrap=%b want 0 0000001 0 0", digit, seg, tick, wrap);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({digit, seg, tick, wrap} !== {4'd0, 7'b0000001, 2'b00}) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got digit=%0d seg=%b tick=%b wrap=%b want 0 0000001 0 0", i, digit, seg, tick, wrap);
      end
    end
  endtask

  task automatic test_count_up();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= MAX; k++) begin
      step();
      n_cmp++;
      if (seg !== SEG[k-1] || tick !== 1'b0) begin
        n_bad++;
        $display("FAIL up_seg k=%0d got seg=%b tick=%b want %b 0", k, seg, tick, SEG[k-1]);
      end
      step(); step();
      n_cmp++;
      if (tick !== 1'b1 || digit !== 4'(k-1)) begin
        n_bad++;
        $display("FAIL up_tick k=%0d got tick=%b digit=%0d want 1 %0d", k, tick, digit, k-1);
      end
      step();
      n_cmp++;
      if (digit !== 4'(k) || tick !== 1'b0 || wrap !== 1'b0 || seg !== SEG[k-1]) begin
        n_bad++;
        $display("FAIL up_digit k=%0d got digit=%0d tick=%b wrap=%b seg=%b want %0d 0 0 %b",
                 k, digit, tick, wrap, seg, k, SEG[k-1]);
      end
    end
  endtask

  task automatic test_wrap();
    step();
    n_cmp++;
    if (seg !== SEG[MAX]) begin
      n_bad++;
      $display("FAIL max_seg got %b want %b", seg, SEG[MAX]);
    end
    step(); step();
    n_cmp++;
    if (tick !== 1'b1 || digit !== 4'(MAX)) begin
      n_bad++;
      $display("FAIL wrap_up_tick got tick=%b digit=%0d want 1 %0d", tick, digit, MAX);
    end
    step();
    n_cmp++;
    if (digit !== 4'd0 || wrap !== 1'b1 || seg !== SEG[MAX]) begin
      n_bad++;
      $display("FAIL wrap_up got digit=%0d wrap=%b seg=%b want 0 1 %b", digit, wrap, seg, SEG[MAX]);
    end
    up = 1'b0;
    step();
    n_cmp++;
    if (wrap !== 1'b0 || seg !== SEG[0]) begin
      n_bad++;
      $display("FAIL wrap_up_pulse got wrap=%b seg=%b want 0 %b", wrap, seg, SEG[0]);
    end
    step(); step();
    n_cmp++;
    if (tick !== 1'b1 || digit !== 4'd0) begin
      n_bad++;
      $display("FAIL wrap_dn_tick got tick=%b digit=%0d want 1 0", tick, digit);
    end
    step();
    n_cmp++;
    if (digit !== 4'(MAX) || wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_dn got digit=%0d wrap=%b want %0d 1", digit, wrap, MAX);
    end
    step();
    n_cmp++;
    if (wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_dn_pulse got wrap=%b want 0", wrap);
    end
  endtask

  task automatic test_load_vs_tick();
    up = 1'b1;
    step(); step();
    n_cmp++;
    if (tick !== 1'b1 || digit !== 4'(MAX)) begin
      n_bad++;
      $display("FAIL load_pre got tick=%b digit=%0d want 1 %0d", tick, digit, MAX);
    end
    load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    n_cmp++;
    if (digit !== 4'd7 || wrap !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL load7 got digit=%0d wrap=%b tick=%b want 7 0 0", digit, wrap, tick);
    end
    step(); step();
    n_cmp++;
    if (tick !== 1'b0) begin
      n_bad++;
      $display("FAIL load_phase_early got tick=%b want 0", tick);
    end
    step();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_bad++;
      $display("FAIL load_phase got tick=%b want 1", tick);
    end
    step();
    n_cmp++;
    if (digit !== 4'd8 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL load_next got digit=%0d wrap=%b want 8 0", digit, wrap);
    end
    load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    n_cmp++;
    if (digit !== 4'(LOAD12) || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL load12 got digit=%0d wrap=%b want %0d 0", digit, wrap, LOAD12);
    end
    step();
    n_cmp++;
    if (seg !== SEG[LOAD12]) begin
      n_bad++;
      $display("FAIL load12_seg got %b want %b", seg, SEG[LOAD12]);
    end
  endtask

  task automatic test_hold();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (digit !== 4'(LOAD12) || tick !== 1'b0 || wrap !== 1'b0 || seg !== SEG[LOAD12]) begin
        n_bad++;
        $display("FAIL hold cyc=%0d got digit=%0d tick=%b wrap=%b seg=%b want %0d 0 0 %b",
                 i, digit, tick, wrap, seg, LOAD12, SEG[LOAD12]);
      end
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_resume_phase got tick=%b want 1", tick);
    end
    step();
    n_cmp++;
    if (digit !== 4'(LOAD12 + 1)) begin
      n_bad++;
      $display("FAIL hold_resume got digit=%0d want %0d", digit, LOAD12 + 1);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0;
    step();
    n_cmp++;
    if (digit !== 4'd5 || seg !== SEG[5]) begin
      n_bad++;
      $display("FAIL arst_pre got digit=%0d seg=%b want 5 %b", digit, seg, SEG[5]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({digit, seg, tick, wrap} !== {4'd0, 7'b0000001, 2'b00}) begin
      n_bad++;
      $display("FAIL arst got digit=%0d seg=%b tick=%b wrap=%b want 0 0000001 0 0", digit, seg, tick, wrap);
    end
    #2;
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if (tick !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_early_tick got tick=%b want 0", tick);
    end
    step();
    n_cmp++;
    if (tick !== 1'b1 || digit !== 4'd0) begin
      n_bad++;
      $display("FAIL arst_first_tick got tick=%b digit=%0d want 1 0", tick, digit);
    end
    step();
    n_cmp++;
    if (digit !== 4'd1) begin
      n_bad++;
      $display("FAIL arst_count got digit=%0d want 1", digit);
    end
  endtask

  initial begin
    SEG[0]  = 7'b0000001; SEG[1]  = 7'b1001111; SEG[2]  = 7'b0010010; SEG[3]  = 7'b0000110;
    SEG[4]  = 7'b1001100; SEG[5]  = 7'b0100100; SEG[6]  = 7'b0100000; SEG[7]  = 7'b0001111;
    SEG[8]  = 7'b0000000; SEG[9]  = 7'b0000100;
`ifdef HEX_MODE_EN
    SEG[10] = 7'b0001000; SEG[11] = 7'b1100000; SEG[12] = 7'b0110001; SEG[13] = 7'b1000010;
    SEG[14] = 7'b0110000; SEG[15] = 7'b0111000;
`else
    for (int i = 10; i < 16; i++) SEG[i] = 7'b1111111;
`endif
    test_reset();
    test_count_up();
    test_wrap();
    test_load_vs_tick();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
